// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port fixed-latency memory arbiter/sequencer for fetch and data
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        m_en,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        busy
);

   localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic [3:0] starve_cnt;
   logic       owner_d;     // 1 = data port owns the access in flight
   logic       if_vis;
   logic       d_vis;
   logic       pick_if;
   logic       grant;
   logic       resp_done;

   // Mask the current owner during its ack cycle, arbitrate, and choose the next state
   always_comb begin
      state_nxt = state;
      if_vis    = if_req & ~((state == RESP) & ~owner_d);
      d_vis     = d_req  & ~((state == RESP) &  owner_d);
      pick_if   = if_vis & (~d_vis | (starve_cnt == STARVE_LIM));
      grant     = ((state == IDLE) | (state == RESP)) & (if_vis | d_vis);
      resp_done = (state == WAIT) & (cnt == 4'd1);
      case (state)
         IDLE:    if (grant) state_nxt = CMD;
         CMD:     state_nxt = WAIT;
         WAIT:    if (resp_done) state_nxt = RESP;
         RESP:    state_nxt = grant ? CMD : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Command strobe and latched command fields; the latches double as the memory command outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_en    <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= 32'd0;
         m_wdata <= 32'd0;
         owner_d <= 1'b0;
         busy    <= 1'b0;
      end else begin
         m_en <= grant;
         busy <= (state_nxt != IDLE);
         if (grant) begin
            owner_d <= ~pick_if;
            m_we    <= pick_if ? 1'b0 : d_we;
            m_addr  <= pick_if ? if_addr : d_addr;
            m_wdata <= pick_if ? 32'd0 : d_wdata;
         end
      end
   end

   // Latency counter and fetch starvation counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= 4'd0;
         starve_cnt <= 4'd0;
      end else begin
         if (state == CMD)       cnt <= LAT_INIT;
         else if (state == WAIT) cnt <= cnt - 4'd1;
         if (grant) begin
            if (pick_if)                                starve_cnt <= 4'd0;
            else if (if_vis && starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end

   // Capture the memory response into the owner's port and pulse its ack; stores leave d_rdata alone
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_ack   <= 1'b0;
         d_ack    <= 1'b0;
         if_rdata <= 32'd0;
         d_rdata  <= 32'd0;
      end else begin
         if_ack <= resp_done & ~owner_d;
         d_ack  <= resp_done &  owner_d;
         if (resp_done && !owner_d)        if_rdata <= m_rdata;
         if (resp_done && owner_d && !m_we) d_rdata <= m_rdata;
      end
   end

   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed-vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int MEM_LAT    = 2;
   localparam int STARVE_MAX = 4;
   localparam int N          = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b1;
   logic [31:0] if_addr = 32'h10;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = 32'd0;
   logic [31:0] d_wdata = 32'd0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        m_en;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        stall_if;
   logic        stall_mem;
   logic        busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
   );

   // Memory model: data valid exactly MEM_LAT cycles after m_en, garbage otherwise
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h10:  return 32'hDEADBEEF;
         32'h100: return 32'h00001234;
         default: return a ^ 32'hA5A50000;
      endcase
   endfunction

   logic [MEM_LAT-1:0] pipe_vld = '0;
   logic [31:0]        pipe_data [MEM_LAT];

   always @(posedge clk) begin
      pipe_vld[0]  <= m_en;
      pipe_data[0] <= mem_word(m_addr);
      for (int i = 1; i < MEM_LAT; i++) begin
         pipe_vld[i]  <= pipe_vld[i-1];
         pipe_data[i] <= pipe_data[i-1];
      end
   end
   assign m_rdata = pipe_vld[MEM_LAT-1] ? pipe_data[MEM_LAT-1] : 32'hBAD0BAD0;

   // Per-cycle log, sampled mid-cycle on the falling edge
   int          cyc = 0;
   logic        lg_men [N];
   logic        lg_mwe [N];
   logic        lg_ifack [N];
   logic        lg_dack [N];
   logic        lg_busy [N];
   logic        lg_sif [N];
   logic        lg_smem [N];
   logic [31:0] lg_maddr [N];
   logic [31:0] lg_mwdata [N];
   logic [31:0] lg_ifrd [N];
   logic [31:0] lg_drd [N];
   logic [31:0] grant_q [$];
   int          overlap = 0;
   int          consec = 0;
   logic        prev_men = 1'b0;

   always @(negedge clk) begin
      if (if_ack && d_ack) overlap++;
      if (m_en && prev_men) consec++;
      prev_men = m_en;
      if (m_en) grant_q.push_back(m_addr);
      if (cyc >= 0 && cyc < N) begin
         lg_men[cyc]    = m_en;
         lg_mwe[cyc]    = m_we;
         lg_ifack[cyc]  = if_ack;
         lg_dack[cyc]   = d_ack;
         lg_busy[cyc]   = busy;
         lg_sif[cyc]    = stall_if;
         lg_smem[cyc]   = stall_mem;
         lg_maddr[cyc]  = m_addr;
         lg_mwdata[cyc] = m_wdata;
         lg_ifrd[cyc]   = if_rdata;
         lg_drd[cyc]    = d_rdata;
      end
      cyc++;
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Cycle 0 of a test is the cycle that begins here
   task automatic begin_test();
      next_cycle();
      cyc = 0;
   endtask

   // Advance until the log holds cycle last-1; requesters drop the cycle after their ack
   task automatic run_until(input int last);
      while (cyc < last && cyc < N) begin
         next_cycle();
         if (lg_ifack[cyc-1]) if_req = 1'b0;
         if (lg_dack[cyc-1])  d_req  = 1'b0;
      end
   endtask

   logic [31:0] exp_grants [6] = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h40, 32'h210};
   int          nd;
   logic        fetch_done;
   logic [3:0]  sc_max;
   logic [3:0]  sc_fetch;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state, fetch request already pending
      repeat (3) next_cycle();
      check("rst m_en", m_en, 0);
      check("rst busy", busy, 0);
      check("rst if_ack", if_ack, 0);
      check("rst d_ack", d_ack, 0);
      check("rst m_addr", m_addr, 0);
      check("rst if_rdata", if_rdata, 0);
      check("rst stall_if", stall_if, 1);
      check("rst stall_mem", stall_mem, 0);

      // Single fetch released straight out of reset
      begin_test();
      rst = 1'b1;
      run_until(7);
      check("t1 m_en c0", lg_men[0], 0);
      check("t1 m_en c1", lg_men[1], 1);
      check("t1 m_addr c1", lg_maddr[1], 32'h10);
      check("t1 m_en c2", lg_men[2], 0);
      check("t1 if_ack c3", lg_ifack[3], 0);
      check("t1 if_ack c4", lg_ifack[4], 1);
      check("t1 if_rdata c4", lg_ifrd[4], 32'hDEADBEEF);
      check("t1 if_ack c5", lg_ifack[5], 0);
      check("t1 stall_if c0", lg_sif[0], 1);
      check("t1 stall_if c3", lg_sif[3], 1);
      check("t1 stall_if c4", lg_sif[4], 0);
      check("t1 busy c5", lg_busy[5], 0);

      // Contention: data wins, fetch follows
      begin_test();
      if_req = 1'b1; if_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      run_until(11);
      check("t2 m_en c1", lg_men[1], 1);
      check("t2 m_addr c1", lg_maddr[1], 32'h100);
      check("t2 d_ack c4", lg_dack[4], 1);
      check("t2 d_rdata c4", lg_drd[4], 32'h1234);
      check("t2 if_ack c4", lg_ifack[4], 0);
      check("t2 stall_mem c3", lg_smem[3], 1);
      check("t2 stall_mem c4", lg_smem[4], 0);
      check("t2 m_en c5", lg_men[5], 1);
      check("t2 m_addr c5", lg_maddr[5], 32'h40);
      check("t2 stall_if c7", lg_sif[7], 1);
      check("t2 if_ack c8", lg_ifack[8], 1);
      check("t2 if_rdata c8", lg_ifrd[8], 32'hA5A50040);
      check("t2 stall_if c8", lg_sif[8], 0);
      check("t2 busy c9", lg_busy[9], 0);

      // Store: same timing, d_rdata untouched
      begin_test();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55;
      run_until(7);
      check("t3 m_en c1", lg_men[1], 1);
      check("t3 m_we c1", lg_mwe[1], 1);
      check("t3 m_addr c1", lg_maddr[1], 32'h20);
      check("t3 m_wdata c1", lg_mwdata[1], 32'h55);
      check("t3 d_ack c4", lg_dack[4], 1);
      check("t3 d_rdata c5", lg_drd[5], 32'h1234);
      d_we = 1'b0;

      // Back-to-back fetch: masked in the ack cycle, new address one cycle later
      begin_test();
      if_req = 1'b1; if_addr = 32'h10;
      for (int k = 1; k <= 11; k++) begin
         next_cycle();
         if (cyc == 5)  if_addr = 32'h14;
         if (cyc == 10) if_req = 1'b0;
      end
      check("t4 if_ack c4", lg_ifack[4], 1);
      check("t4 busy c4", lg_busy[4], 1);
      check("t4 busy c5", lg_busy[5], 0);
      check("t4 m_en c5", lg_men[5], 0);
      check("t4 m_en c6", lg_men[6], 1);
      check("t4 m_addr c6", lg_maddr[6], 32'h14);
      check("t4 busy c6", lg_busy[6], 1);
      check("t4 if_ack c8", lg_ifack[8], 0);
      check("t4 if_ack c9", lg_ifack[9], 1);
      check("t4 if_rdata c5", lg_ifrd[5], 32'hDEADBEEF);
      check("t4 if_rdata c9", lg_ifrd[9], 32'hA5A50014);

      // Starvation: fetch withdraws during each data ack cycle so every data grant
      // is made from IDLE with both requests present
      begin_test();
      grant_q.delete();
      nd = 0; fetch_done = 1'b0; sc_max = 4'd0; sc_fetch = 4'hF;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      if_req = 1'b1; if_addr = 32'h40;
      while (grant_q.size() < 6 && cyc < 80) begin
         next_cycle();
         if (lg_dack[cyc-1]) begin
            nd++;
            d_addr = 32'h200 + 32'(4 * nd);
         end
         if (lg_ifack[cyc-1]) fetch_done = 1'b1;
         if_req = ~fetch_done & ~d_ack;
         if (dut.starve_cnt > sc_max) sc_max = dut.starve_cnt;
         if (m_en && m_addr == 32'h40) sc_fetch = dut.starve_cnt;
      end
      check("t5 in time", (cyc < 80), 1);
      check("t5 grants", grant_q.size(), 6);
      for (int i = 0; i < 6; i++)
         check($sformatf("t5 grant%0d", i), (i < grant_q.size()) ? grant_q[i] : 32'hFFFFFFFF, exp_grants[i]);
      check("t5 starve peak", sc_max, 4'(STARVE_MAX));
      check("t5 starve after fetch", sc_fetch, 0);
      if_req = 1'b0;
      run_until(cyc + 8);
      check("t5 starve end", dut.starve_cnt, 0);
      check("t5 idle", busy, 0);

      // Reset during WAIT
      begin_test();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      next_cycle();
      next_cycle();
      check("t6 busy before rst", busy, 1);
      rst = 1'b0;
      #1;
      check("t6 rst busy", busy, 0);
      check("t6 rst m_addr", m_addr, 0);
      check("t6 rst d_rdata", d_rdata, 0);
      check("t6 rst if_rdata", if_rdata, 0);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         check("t6 no ack in rst", d_ack, 0);
      end
      begin_test();
      rst = 1'b1;
      run_until(7);
      check("t6 m_en c0", lg_men[0], 0);
      check("t6 m_en c1", lg_men[1], 1);
      check("t6 m_addr c1", lg_maddr[1], 32'h300);
      check("t6 d_ack c3", lg_dack[3], 0);
      check("t6 d_ack c4", lg_dack[4], 1);
      check("t6 d_rdata c4", lg_drd[4], 32'hA5A50300);

      check("never both acks", overlap, 0);
      check("never m_en twice", consec, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
